// File: rtl/tlp_pkg.sv
// Shared symbols, state encoding and sizing helpers for the TLP transmit framer.
package tlp_pkg;

    localparam logic [7:0] STP_SYM  = 8'hFB;
    localparam logic [7:0] END_SYM  = 8'hFD;
    localparam logic [7:0] IDLE_SYM = 8'h00;

    localparam int TLP_PAYLOAD_BYTES = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STP,
        ST_PAY,
        ST_CHK,
        ST_END,
        ST_GAP
    } tx_state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tlp_framer_if.sv
// TLP source handshake plus the framed symbol stream and status seen by the consumer.
interface tlp_framer_if #(
    parameter int PAYLOAD_BYTES = 20,
    parameter int COUNT_W       = 8
);
    logic                       tlp_valid;
    logic                       tlp_ready;
    logic [8*PAYLOAD_BYTES-1:0] tlp_data;
    logic [7:0]                 data_out;
    logic                       datak;
    logic                       busy;
    logic [COUNT_W-1:0]         tx_count;

    modport master (
        output tlp_valid, tlp_data,
        input  tlp_ready, data_out, datak, busy, tx_count
    );

    modport slave (
        input  tlp_valid, tlp_data,
        output tlp_ready, data_out, datak, busy, tx_count
    );
endinterface

// File: rtl/tlp_framer_up_down_counter.sv
// Generic wrapping up/down counter with synchronous clear and active-low sync reset.
module up_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_up,
    input  logic         i_dn,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset)             r_cnt <= '0;
        else if (i_clr)         r_cnt <= '0;
        else if (i_up && !i_dn) r_cnt <= r_cnt + 1'b1;
        else if (i_dn && !i_up) r_cnt <= r_cnt - 1'b1;
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/tlp_framer.sv
// Serialises one TLP per handshake as STP, payload (LSB byte first), END; counts completed TLPs.
// Optional TLP_FRAMER_CHKSUM_EN inserts an XOR-of-payload byte between the last payload byte and END.
module tlp_framer
    import tlp_pkg::*;
#(
    parameter int PAYLOAD_BYTES = TLP_PAYLOAD_BYTES,
    parameter int COUNT_W       = 8,
    parameter int MIN_GAP       = 0
) (
    input logic         clk,
    input logic         reset,
    tlp_framer_if.slave bus
);
    localparam int IDX_W = cnt_w(PAYLOAD_BYTES);
    localparam int GAP_W = cnt_w(MIN_GAP);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PAYLOAD_BYTES - 1);
    // The IDLE cycle that follows GAP supplies the final idle symbol, so GAP lasts MIN_GAP-1 cycles.
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(MIN_GAP - 2);
    localparam logic             END_READY = (MIN_GAP == 0);

    tx_state_e                  r_state;
    logic [7:0]                 r_data;
    logic                       r_k;
    logic                       r_busy;
    logic                       r_ready;
    logic [8*PAYLOAD_BYTES-1:0] r_shift;
    logic [GAP_W-1:0]           r_gap;
`ifdef TLP_FRAMER_CHKSUM_EN
    logic [7:0]                 r_chk;
`endif
    logic                       w_accept;
    logic [IDX_W-1:0]           w_idx;
    logic [COUNT_W-1:0]         w_cnt;

    assign w_accept = bus.tlp_valid && r_ready;

    up_down_counter #(.W(IDX_W)) u_byte_idx (
        .clk(clk), .reset(reset),
        .i_clr(r_state == ST_STP), .i_up(r_state == ST_PAY), .i_dn(1'b0),
        .o_cnt(w_idx)
    );

    up_down_counter #(.W(COUNT_W)) u_tx_count (
        .clk(clk), .reset(reset),
        .i_clr(1'b0), .i_up(r_state == ST_END), .i_dn(1'b0),
        .o_cnt(w_cnt)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_data  <= IDLE_SYM;
            r_k     <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_shift <= '0;
            r_gap   <= '0;
`ifdef TLP_FRAMER_CHKSUM_EN
            r_chk   <= '0;
`endif
        end else if (w_accept) begin
            r_state <= ST_STP;
            r_data  <= STP_SYM;
            r_k     <= 1'b1;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_shift <= bus.tlp_data;
        end else begin
            case (r_state)
                ST_STP: begin
                    r_state <= ST_PAY;
                    r_data  <= r_shift[7:0];
                    r_k     <= 1'b0;
                    r_shift <= r_shift >> 8;
`ifdef TLP_FRAMER_CHKSUM_EN
                    r_chk   <= r_shift[7:0];
`endif
                end
                ST_PAY: begin
                    if (w_idx == LAST_IDX) begin
`ifdef TLP_FRAMER_CHKSUM_EN
                        r_state <= ST_CHK;
                        r_data  <= r_chk;
`else
                        r_state <= ST_END;
                        r_data  <= END_SYM;
                        r_k     <= 1'b1;
                        r_ready <= END_READY;
`endif
                    end else begin
                        r_data  <= r_shift[7:0];
                        r_shift <= r_shift >> 8;
`ifdef TLP_FRAMER_CHKSUM_EN
                        r_chk   <= r_chk ^ r_shift[7:0];
`endif
                    end
                end
`ifdef TLP_FRAMER_CHKSUM_EN
                ST_CHK: begin
                    r_state <= ST_END;
                    r_data  <= END_SYM;
                    r_k     <= 1'b1;
                    r_ready <= END_READY;
                end
`endif
                ST_END: begin
                    r_data <= IDLE_SYM;
                    r_k    <= 1'b0;
                    r_busy <= 1'b0;
                    if (MIN_GAP > 1) begin
                        r_state <= ST_GAP;
                        r_ready <= 1'b0;
                        r_gap   <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_data  <= IDLE_SYM;
                    r_k     <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tlp_ready = r_ready;
    assign bus.data_out  = r_data;
    assign bus.datak     = r_k;
    assign bus.busy      = r_busy;
    assign bus.tx_count  = w_cnt;
endmodule
